// File: rtl/ascon_sbox_ti_pipe.sv
// Three-share threshold Ascon S-box layer: component functions, register barrier, optional remask stage.
// Global-enable elastic pipeline; latency 1+REMASK cycles, one share set per cycle.
module ascon_sbox_ti_pipe #(
  parameter int W      = 64,
  parameter bit REMASK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5*W-1:0]  x_s0,
  input  logic [5*W-1:0]  x_s1,
  input  logic [5*W-1:0]  x_s2,
  input  logic [10*W-1:0] rnd_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5*W-1:0]  y_s0,
  output logic [5*W-1:0]  y_s1,
  output logic [5*W-1:0]  y_s2,
  output logic            busy
);
  localparam int LAT = 1 + int'(REMASK);

  typedef logic [5*W-1:0] st_t;

  function automatic st_t pre_lin(input st_t x);
    st_t y;
    y = x;
    y[0*W +: W] = x[0*W +: W] ^ x[4*W +: W];
    y[4*W +: W] = x[4*W +: W] ^ x[3*W +: W];
    y[2*W +: W] = x[2*W +: W] ^ x[1*W +: W];
    return y;
  endfunction

  // Share j supplies the linear term; the AND cross terms use shares j and k only,
  // so a component never sees the share whose index it carries.
  function automatic st_t comp(input st_t pj, input st_t pk, input logic inv);
    logic [W-1:0] lj [5];
    logic [W-1:0] lk [5];
    logic [W-1:0] c  [5];
    st_t          y;
    for (int l = 0; l < 5; l++) begin
      lj[l] = pj[l*W +: W];
      lk[l] = pk[l*W +: W];
    end
    for (int l = 0; l < 5; l++) begin
      c[l] = lj[l] ^ lj[(l+2)%5]
           ^ (lj[(l+1)%5] & lj[(l+2)%5])
           ^ (lj[(l+1)%5] & lk[(l+2)%5])
           ^ (lk[(l+1)%5] & lj[(l+2)%5]);
    end
    y[0*W +: W] = c[0] ^ c[4];
    y[1*W +: W] = c[1] ^ c[0];
    y[2*W +: W] = inv ? ~c[2] : c[2];
    y[3*W +: W] = c[3] ^ c[2];
    y[4*W +: W] = c[4];
    return y;
  endfunction

  st_t  p0, p1, p2, f0, f1, f2;
  st_t  a0_q, a1_q, a2_q;
  logic va_q;
  logic adv;

  assign p0 = pre_lin(x_s0);
  assign p1 = pre_lin(x_s1);
  assign p2 = pre_lin(x_s2);
  assign f0 = comp(p1, p2, 1'b1);
  assign f1 = comp(p2, p0, 1'b0);
  assign f2 = comp(p0, p1, 1'b0);

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      va_q <= 1'b0;
      a0_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
    end else if (adv) begin
      va_q <= in_valid;
      a0_q <= f0;
      a1_q <= f1;
      a2_q <= f2;
    end
  end

  generate
    if (LAT == 2) begin : g_remask
      st_t  r_a, r_b;
      st_t  y0_q, y1_q, y2_q;
      logic vb_q;

      assign r_a = rnd_i[5*W-1:0];
      assign r_b = rnd_i[10*W-1:5*W];

      always_ff @(posedge clk) begin
        if (rst) begin
          vb_q <= 1'b0;
          y0_q <= '0;
          y1_q <= '0;
          y2_q <= '0;
        end else if (adv) begin
          vb_q <= va_q;
          y0_q <= a0_q ^ r_a;
          y1_q <= a1_q ^ r_b;
          y2_q <= a2_q ^ r_a ^ r_b;
        end
      end

      assign out_valid = vb_q;
      assign y_s0      = y0_q;
      assign y_s1      = y1_q;
      assign y_s2      = y2_q;
      assign busy      = va_q | vb_q;
    end else begin : g_direct
      logic unused_rnd;
      assign unused_rnd = ^rnd_i;
      assign out_valid  = va_q;
      assign y_s0       = a0_q;
      assign y_s1       = a1_q;
      assign y_s2       = a2_q;
      assign busy       = va_q;
    end
  endgenerate

endmodule

// File: tb/tb_ascon_sbox_ti_pipe.sv
// Directed bench for the shared Ascon S-box pipeline: W=64 remasking build plus a W=32 direct build.
module tb_ascon_sbox_ti_pipe;
  typedef logic [319:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [319:0] x_s0, x_s1, x_s2, y_s0, y_s1, y_s2;
  logic [639:0] rnd_i;

  logic         d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy;
  logic [159:0] d_x0, d_x1, d_x2, d_y0, d_y1, d_y2;
  logic [319:0] d_rnd;

  ascon_sbox_ti_pipe #(.W(64), .REMASK(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_s0(x_s0), .x_s1(x_s1), .x_s2(x_s2), .rnd_i(rnd_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_s0(y_s0), .y_s1(y_s1), .y_s2(y_s2), .busy(busy)
  );

  ascon_sbox_ti_pipe #(.W(32), .REMASK(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .x_s0(d_x0), .x_s1(d_x1), .x_s2(d_x2), .rnd_i(d_rnd),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .y_s0(d_y0), .y_s1(d_y1), .y_s2(d_y2), .busy(d_busy)
  );

  int   total = 0;
  int   bad   = 0;
  vec_t q[$];
  bit   stall_prev;
  vec_t hold0, hold1, hold2;
  int   got;

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] sbox(input logic [4:0] i);
    case (i)
      5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
      5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
      5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
      5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
      5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
      5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
      5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
      5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
    endcase
  endfunction

  function automatic vec_t golden(input vec_t x, input int w);
    vec_t       y;
    logic [4:0] idx, o;
    y = '0;
    for (int b = 0; b < w; b++) begin
      idx = {x[b], x[w+b], x[2*w+b], x[3*w+b], x[4*w+b]};
      o   = sbox(idx);
      y[b] = o[4]; y[w+b] = o[3]; y[2*w+b] = o[2]; y[3*w+b] = o[1]; y[4*w+b] = o[0];
    end
    return y;
  endfunction

  function automatic vec_t rnd320();
    vec_t v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One cycle on the W=64 instance: drive, sample at negedge, score, then advance.
  task automatic cyc(input bit iv, input vec_t x, input bit ordy, output bit acc);
    vec_t m1, m2;
    m1 = rnd320();
    m2 = rnd320();
    in_valid  = iv;
    x_s0      = x ^ m1 ^ m2;
    x_s1      = m1;
    x_s2      = m2;
    rnd_i     = {rnd320(), rnd320()};
    out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && !out_ready) begin
      if (stall_prev) begin
        chk("hold_s0", y_s0, hold0);
        chk("hold_s1", y_s1, hold1);
        chk("hold_s2", y_s2, hold2);
      end
      hold0 = y_s0; hold1 = y_s1; hold2 = y_s2;
      stall_prev = 1'b1;
    end else begin
      stall_prev = 1'b0;
    end
    if (out_valid && out_ready) begin
      got++;
      chk("pending", vec_t'(q.size() != 0), vec_t'(1));
      if (q.size() != 0) chk("stream", y_s0 ^ y_s1 ^ y_s2, q.pop_front());
    end
    if (acc) q.push_back(golden(x, 64));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 8 && q.size() != 0; k++) cyc(1'b0, '0, 1'b1, acc);
    chk("drain", vec_t'(q.size()), '0);
  endtask

  task automatic run_lat(input string tag, input vec_t x, input vec_t m1, input vec_t m2,
                         input logic [639:0] r, input vec_t exp);
    in_valid = 1'b1; x_s0 = x ^ m1 ^ m2; x_s1 = m1; x_s2 = m2; rnd_i = r; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, vec_t'(in_ready), vec_t'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, vec_t'(out_valid), '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_vld"}, vec_t'(out_valid), vec_t'(1));
    chk({tag, "_dat"}, y_s0 ^ y_s1 ^ y_s2, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t        x, e, base, m1, m2, flip, rec, obs;
    vec_t        v [3];
    bit          acc;
    int          sent;
    logic [159:0] ref0, ref1, ref2;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_s0 = '0; x_s1 = '0; x_s2 = '0; rnd_i = '0;
    d_in_valid = 1'b0; d_out_ready = 1'b1; d_x0 = '0; d_x1 = '0; d_x2 = '0; d_rnd = '0;
    stall_prev = 1'b0; got = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld",  vec_t'(out_valid), '0);
    chk("rst_busy", vec_t'(busy), '0);
    chk("rst_rdy",  vec_t'(in_ready), vec_t'(1));
    chk("rst_y",    y_s0 | y_s1 | y_s2, '0);
    chk("d2_rst_vld", vec_t'(d_out_valid), '0);
    @(posedge clk); #1;

    // All-zero input, zero randomness: Sbox(0)=0x04 sets lane x2
    e = '0; e[128 +: 64] = '1;
    run_lat("zero", '0, '0, '0, '0, e);

    // x0 lane ones with equal masks: Sbox(0x10)=0x1e
    x = '0; x[63:0] = '1;
    e = '0; e[255:0] = '1;
    m1 = rnd320();
    run_lat("x0ones", x, m1, m1, {rnd320(), rnd320()}, e);

    // Streaming: first vector walks every column index, rest random
    x = '0;
    for (int b = 0; b < 64; b++)
      for (int l = 0; l < 5; l++) x[l*64 + b] = b[4-l];
    cyc(1'b1, x, 1'b1, acc);
    for (int i = 0; i < 160; i++) cyc(1'b1, rnd320(), 1'b1, acc);
    drain();

    // Component i must not depend on share i
    for (int i = 0; i < 3; i++) begin
      base = rnd320(); m1 = rnd320(); m2 = rnd320(); flip = rnd320() | vec_t'(1);
      in_valid = 1'b1; out_ready = 1'b1;
      x_s0 = base; x_s1 = m1; x_s2 = m2;
      @(posedge clk); #1;
      rec = (i == 0) ? u_dut.a0_q : (i == 1) ? u_dut.a1_q : u_dut.a2_q;
      if (i == 0) x_s0 = base ^ flip; else if (i == 1) x_s1 = m1 ^ flip; else x_s2 = m2 ^ flip;
      @(posedge clk); #1;
      obs = (i == 0) ? u_dut.a0_q : (i == 1) ? u_dut.a1_q : u_dut.a2_q;
      chk($sformatf("noncomp%0d", i), obs, rec);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: out_ready low for 5 cycles while 3 sets are offered
    for (int i = 0; i < 3; i++) v[i] = rnd320();
    sent = 0; got = 0; stall_prev = 1'b0;
    for (int c = 0; c < 20 && (sent < 3 || q.size() != 0); c++) begin
      cyc(sent < 3, (sent < 3) ? v[sent] : '0, c >= 5, acc);
      if (acc) sent++;
      if (c == 2) begin
        chk("full_acc", vec_t'(acc), '0);
        chk("full_rdy", vec_t'(in_ready), '0);
      end
    end
    chk("bp_count", vec_t'(got), vec_t'(3));
    chk("bp_left",  vec_t'(q.size()), '0);

    // Reset with two sets in flight
    cyc(1'b1, rnd320(), 1'b1, acc);
    cyc(1'b1, rnd320(), 1'b1, acc);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_vld",  vec_t'(out_valid), '0);
    chk("mid_busy", vec_t'(busy), '0);
    chk("mid_rdy",  vec_t'(in_ready), vec_t'(1));
    chk("mid_y",    y_s0 | y_s1 | y_s2, '0);
    @(posedge clk); #1;
    cyc(1'b1, rnd320(), 1'b1, acc);
    drain();

    // W=32 direct build: single-cycle latency, randomness has no effect
    m1 = rnd320();
    m2 = rnd320();
    e = '0; e[64 +: 32] = '1;
    for (int pass = 0; pass < 2; pass++) begin
      d_in_valid = 1'b1; d_x0 = m1[159:0] ^ m2[159:0]; d_x1 = m1[159:0]; d_x2 = m2[159:0];
      d_rnd = rnd320();
      @(negedge clk);
      chk("d2_rdy", vec_t'(d_in_ready), vec_t'(1));
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      @(negedge clk);
      chk("d2_vld", vec_t'(d_out_valid), vec_t'(1));
      chk("d2_dat", vec_t'(d_y0 ^ d_y1 ^ d_y2), e);
      if (pass == 0) begin
        ref0 = d_y0; ref1 = d_y1; ref2 = d_y2;
      end else begin
        chk("d2_rnd_ign", vec_t'({d_y0, d_y1, d_y2}), vec_t'({ref0, ref1, ref2}));
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("d2_idle", vec_t'(d_busy), '0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
